// File: rtl/button_pkg.sv
// Shared types and constants for the push-button front end: channel FSM states,
// counter sizing and default timing counts for a 50 MHz clock.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } channel_state_e;

  localparam int DEFAULT_CLK_HZ = 50_000_000;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // One spare bit above $clog2 so the largest count is always representable.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int DEFAULT_DEBOUNCE_CYCLES     = ms_to_cycles(DEFAULT_CLK_HZ, 20);
  localparam int DEFAULT_REPEAT_DELAY_CYCLES = ms_to_cycles(DEFAULT_CLK_HZ, 500);
  localparam int DEFAULT_REPEAT_RATE_CYCLES  = ms_to_cycles(DEFAULT_CLK_HZ, 200);

endpackage

// File: rtl/button_channel.sv
// One button lane: 2-flop synchroniser, debounce FSM with one-cycle press pulse,
// debounced pressed level and optional hold-to-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES,
  parameter bit REPEAT_EN           = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_button,
  output logic pulse,
  output logic pressed
);

  localparam int CNT_W = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
  localparam logic [CNT_W-1:0] DEBOUNCE_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LIMIT    = CNT_W'(REPEAT_DELAY_CYCLES);
  localparam logic [CNT_W-1:0] RATE_LIMIT     = CNT_W'(REPEAT_RATE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  logic [1:0]       sync_reg;
  channel_state_e   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next, rpt_cnt_inc, rpt_limit;
  logic             rpt_started_reg, rpt_started_next;
  logic             pulse_reg, pulse_next;
  logic             pressed_reg, pressed_next;
  logic             btn_low;

  assign btn_low     = ~sync_reg[1];
  assign cnt_inc     = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_ONE;
  assign rpt_cnt_inc = (&rpt_cnt_reg) ? rpt_cnt_reg : rpt_cnt_reg + CNT_ONE;
  // First repeat waits the long delay, later ones use the shorter rate.
  assign rpt_limit   = rpt_started_reg ? RATE_LIMIT : DELAY_LIMIT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg        <= 2'b11;
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rpt_cnt_reg     <= '0;
      rpt_started_reg <= 1'b0;
      pulse_reg       <= 1'b0;
      pressed_reg     <= 1'b0;
    end else begin
      sync_reg        <= {sync_reg[0], raw_button};
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      rpt_cnt_reg     <= rpt_cnt_next;
      rpt_started_reg <= rpt_started_next;
      pulse_reg       <= pulse_next;
      pressed_reg     <= pressed_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (btn_low) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_low) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_inc >= DEBOUNCE_LIMIT) begin
          state_next = HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HELD: begin
        if (!btn_low) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_low) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_inc >= DEBOUNCE_LIMIT) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pulse_next       = 1'b0;
    pressed_next     = pressed_reg;
    rpt_cnt_next     = rpt_cnt_reg;
    rpt_started_next = rpt_started_reg;
    if (state_reg == PRESS_WAIT && state_next == HELD) begin
      pulse_next       = 1'b1;
      pressed_next     = 1'b1;
      rpt_cnt_next     = '0;
      rpt_started_next = 1'b0;
    end
    if (state_reg == RELEASE_WAIT && state_next == IDLE) begin
      pressed_next = 1'b0;
    end
    // Repeat timing lives only in HELD; any exit discards it.
    if (state_reg == HELD) begin
      if (state_next != HELD) begin
        rpt_cnt_next     = '0;
        rpt_started_next = 1'b0;
      end else if (REPEAT_EN) begin
        if (rpt_cnt_inc >= rpt_limit) begin
          pulse_next       = 1'b1;
          rpt_cnt_next     = '0;
          rpt_started_next = 1'b1;
        end else begin
          rpt_cnt_next = rpt_cnt_inc;
        end
      end
    end
  end

  assign pulse   = pulse_reg;
  assign pressed = pressed_reg;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the clock's three raw active-low buttons into clean press pulses
// and pressed levels; only the add button auto-repeats.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CLK_HZ              = DEFAULT_CLK_HZ,
  parameter int DEBOUNCE_CYCLES     = ms_to_cycles(CLK_HZ, 20),
  parameter int REPEAT_DELAY_CYCLES = ms_to_cycles(CLK_HZ, 500),
  parameter int REPEAT_RATE_CYCLES  = ms_to_cycles(CLK_HZ, 200)
) (
  input  logic clk,
  input  logic rst,
  input  logic set_time_button,
  input  logic set_time_change_button,
  input  logic set_time_add_button,
  output logic set_time_pulse,
  output logic set_time_change_pulse,
  output logic set_time_add_pulse,
  output logic set_time_pressed,
  output logic set_time_change_pressed,
  output logic set_time_add_pressed
);

  localparam int NUM_CH = 3;
  localparam int ADD_CH = 2;

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] pulse_vec;
  logic [NUM_CH-1:0] pressed_vec;

  assign raw_vec = {set_time_add_button, set_time_change_button, set_time_button};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      button_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
        .REPEAT_EN           (gi == ADD_CH)
      ) u_channel (
        .clk        (clk),
        .rst        (rst),
        .raw_button (raw_vec[gi]),
        .pulse      (pulse_vec[gi]),
        .pressed    (pressed_vec[gi])
      );
    end
  endgenerate

  assign set_time_pulse          = pulse_vec[0];
  assign set_time_change_pulse   = pulse_vec[1];
  assign set_time_add_pulse      = pulse_vec[ADD_CH];
  assign set_time_pressed        = pressed_vec[0];
  assign set_time_change_pressed = pressed_vec[1];
  assign set_time_add_pressed    = pressed_vec[ADD_CH];

endmodule
